// File: rtl/hht_operand_mem.sv
// rtl/hht_operand_mem.sv - dual-read operand memory with write port and zero-fill sequencer
// Optional same-edge write-to-read forwarding is enabled by defining HHT_MEM_BYPASS_EN.
module hht_operand_mem #(
    parameter int DEPTH       = 256,
    parameter int AW          = 8,
    parameter int DW          = 32,
    parameter int BASE        = 0,
    parameter int DEFAULT_VAL = 99999
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          RD,
    input  logic [31:0]   addr1,
    input  logic [31:0]   addr2,
    output logic [DW-1:0] dataOut1,
    output logic [DW-1:0] dataOut2,
    output logic          valid1,
    output logic          valid2,
    input  logic          WR,
    input  logic [31:0]   wAddr,
    input  logic [DW-1:0] wData,
    input  logic          mem_init,
    output logic          busy
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam logic [32:0]   LP_LO   = 33'(BASE);
    localparam logic [32:0]   LP_HI   = 33'(BASE + DEPTH);
    localparam logic [AW-1:0] LP_BOFS = AW'(BASE);
    localparam logic [DW-1:0] LP_DEF  = DW'(DEFAULT_VAL);
    localparam logic [AW-1:0] LP_LAST = AW'(DEPTH - 1);

    logic [DW-1:0] r_mem [DEPTH];
    state_t        r_state;
    state_t        w_nxt_state;
    logic [AW-1:0] r_clr_idx;
    logic [AW-1:0] w_nxt_clr_idx;
    logic [DW-1:0] r_data1;
    logic [DW-1:0] r_data2;
    logic          r_valid1;
    logic          r_valid2;

    logic          w_in1;
    logic          w_in2;
    logic          w_inw;
    logic [AW-1:0] w_idx1;
    logic [AW-1:0] w_idx2;
    logic [AW-1:0] w_idxw;
    logic          w_idle;
    logic          w_rd_ok;
    logic          w_wr_ok;
    logic [DW-1:0] w_rdata1;
    logic [DW-1:0] w_rdata2;

    // Index is the offset from BASE; only the low AW bits matter once in range.
    assign w_in1  = ({1'b0, addr1} >= LP_LO) && ({1'b0, addr1} < LP_HI);
    assign w_in2  = ({1'b0, addr2} >= LP_LO) && ({1'b0, addr2} < LP_HI);
    assign w_inw  = ({1'b0, wAddr} >= LP_LO) && ({1'b0, wAddr} < LP_HI);
    assign w_idx1 = addr1[AW-1:0] - LP_BOFS;
    assign w_idx2 = addr2[AW-1:0] - LP_BOFS;
    assign w_idxw = wAddr[AW-1:0] - LP_BOFS;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_rd_ok = RD && w_idle;
    assign w_wr_ok = WR && w_idle && w_inw;

`ifdef HHT_MEM_BYPASS_EN
    assign w_rdata1 = !w_in1 ? LP_DEF :
                      (w_wr_ok && (w_idxw == w_idx1)) ? wData : r_mem[w_idx1];
    assign w_rdata2 = !w_in2 ? LP_DEF :
                      (w_wr_ok && (w_idxw == w_idx2)) ? wData : r_mem[w_idx2];
`else
    assign w_rdata1 = w_in1 ? r_mem[w_idx1] : LP_DEF;
    assign w_rdata2 = w_in2 ? r_mem[w_idx2] : LP_DEF;
`endif

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_clr_idx = r_clr_idx;
        busy          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_init) w_nxt_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                busy          = 1'b1;
                w_nxt_clr_idx = r_clr_idx + 1'b1;
                if (r_clr_idx == LP_LAST) begin
                    w_nxt_state   = ST_IDLE;
                    w_nxt_clr_idx = '0;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state   <= ST_IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_clr_idx <= w_nxt_clr_idx;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_data1  <= '0;
            r_data2  <= '0;
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
        end else begin
            r_valid1 <= w_rd_ok;
            r_valid2 <= w_rd_ok;
            if (w_rd_ok) begin
                r_data1 <= w_rdata1;
                r_data2 <= w_rdata2;
            end
        end
    end

    // Array is not reset; a reset edge must also block any pending clear or write.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            if (r_state == ST_CLEAR) r_mem[r_clr_idx] <= '0;
            else if (w_wr_ok)        r_mem[w_idxw]    <= wData;
        end
    end

    assign dataOut1 = r_data1;
    assign dataOut2 = r_data2;
    assign valid1   = r_valid1;
    assign valid2   = r_valid2;

endmodule

// File: tb/tb_hht_operand_mem.sv
// tb/tb_hht_operand_mem.sv - directed self-checking bench for hht_operand_mem
module tb_hht_operand_mem;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        RD = 1'b0;
    logic [31:0] addr1 = '0;
    logic [31:0] addr2 = '0;
    logic [31:0] dataOut1;
    logic [31:0] dataOut2;
    logic        valid1;
    logic        valid2;
    logic        WR = 1'b0;
    logic [31:0] wAddr = '0;
    logic [31:0] wData = '0;
    logic        mem_init = 1'b0;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    hht_operand_mem dut (
        .Clk(Clk), .Rst(Rst), .RD(RD), .addr1(addr1), .addr2(addr2),
        .dataOut1(dataOut1), .dataOut2(dataOut2), .valid1(valid1), .valid2(valid2),
        .WR(WR), .wAddr(wAddr), .wData(wData), .mem_init(mem_init), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        WR = 1'b1; wAddr = a; wData = d;
        @(negedge Clk);
        WR = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a1, input logic [31:0] a2);
        RD = 1'b1; addr1 = a1; addr2 = a2;
        @(negedge Clk);
        RD = 1'b0;
    endtask

    int busy_cnt;
    int valid_seen;
    logic [31:0] exp_coll;

    initial begin
        // T1 reset with RD asserted
        Rst = 1'b0; RD = 1'b1; addr1 = 32'd3; addr2 = 32'd4;
        repeat (2) @(negedge Clk);
        chk("t1_data1", dataOut1, 32'd0);
        chk("t1_data2", dataOut2, 32'd0);
        chk("t1_valid1", {31'd0, valid1}, 32'd0);
        chk("t1_valid2", {31'd0, valid2}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        Rst = 1'b1; RD = 1'b0;
        @(negedge Clk);

        // T2 preload and read
        wr(32'd180, 32'd5);
        wr(32'd181, 32'd15);
        wr(32'd2, 32'd33);
        rd(32'd181, 32'd2);
        chk("t2_data1", dataOut1, 32'd15);
        chk("t2_data2", dataOut2, 32'd33);
        chk("t2_valid1", {31'd0, valid1}, 32'd1);
        chk("t2_valid2", {31'd0, valid2}, 32'd1);
        @(negedge Clk);
        chk("t2_idle_valid1", {31'd0, valid1}, 32'd0);
        chk("t2_hold_data1", dataOut1, 32'd15);
        rd(32'd180, 32'd180);
        chk("t2_same_addr1", dataOut1, 32'd5);
        chk("t2_same_addr2", dataOut2, 32'd5);

        // T3 out of range read and dropped write (300 aliases index 44 by low bits)
        wr(32'd44, 32'd11);
        rd(32'd256, 32'd2);
        chk("t3_oor_data1", dataOut1, 32'd99999);
        chk("t3_oor_valid1", {31'd0, valid1}, 32'd1);
        chk("t3_inr_data2", dataOut2, 32'd33);
        wr(32'd300, 32'd77);
        rd(32'd44, 32'hFFFF_FFFF);
        chk("t3_alias_kept", dataOut1, 32'd11);
        chk("t3_huge_addr2", dataOut2, 32'd99999);

        // T4 zero-fill, with RD and WR held during busy
        mem_init = 1'b1;
        @(negedge Clk);
        mem_init = 1'b0;
        RD = 1'b1; addr1 = 32'd180; addr2 = 32'd2;
        WR = 1'b1; wAddr = 32'd180; wData = 32'd55;
        busy_cnt = 0; valid_seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            busy_cnt++;
            if (valid1 || valid2) valid_seen++;
            @(negedge Clk);
        end
        RD = 1'b0; WR = 1'b0;
        chk("t4_busy_cycles", busy_cnt, 32'd256);
        chk("t4_valid_during_busy", valid_seen, 32'd0);
        chk("t4_valid_after", {31'd0, valid1}, 32'd0);
        rd(32'd180, 32'd2);
        chk("t4_zero_180", dataOut1, 32'd0);
        chk("t4_zero_2", dataOut2, 32'd0);

        // T5 same-edge read/write collision
        wr(32'd7, 32'd98);
`ifdef HHT_MEM_BYPASS_EN
        exp_coll = 32'd27;
`else
        exp_coll = 32'd98;
`endif
        WR = 1'b1; wAddr = 32'd7; wData = 32'd27;
        RD = 1'b1; addr1 = 32'd7; addr2 = 32'd44;
        @(negedge Clk);
        WR = 1'b0; RD = 1'b0;
        chk("t5_collide_data1", dataOut1, exp_coll);
        chk("t5_other_data2", dataOut2, 32'd0);
        rd(32'd7, 32'd7);
        chk("t5_later_data1", dataOut1, 32'd27);
        chk("t5_later_data2", dataOut2, 32'd27);

        // T6 reset after 100 cleared words
        for (int i = 0; i < 256; i++) wr(i, 32'hAA);
        mem_init = 1'b1;
        @(negedge Clk);
        mem_init = 1'b0;
        repeat (100) @(negedge Clk);
        chk("t6_busy_before_rst", {31'd0, busy}, 32'd1);
        Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        chk("t6_busy_after_rst", {31'd0, busy}, 32'd0);
        rd(32'd99, 32'd100);
        chk("t6_idx99", dataOut1, 32'd0);
        chk("t6_idx100", dataOut2, 32'hAA);
        rd(32'd0, 32'd255);
        chk("t6_idx0", dataOut1, 32'd0);
        chk("t6_idx255", dataOut2, 32'hAA);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
